// File: rtl/fpu_div_ctrl.sv
// Arbitrates two requesters onto one shared combinational divider,
// holds operands for a settle window and returns a tagged quotient.
module fpu_div_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_id,
    output logic        resp_dz,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [3:0] LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  counter;
    logic        last_grant;
    logic        grant0;
    logic        grant1;
    logic        op_id;

    // Tie goes to whoever was not served last; last_grant=1 favours req0.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        unique case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || last_grant);
                grant1 = req1_valid && (!req0_valid || !last_grant);
                if (grant0 || grant1)
                    state_nxt = BUSY;
            end
            BUSY: begin
                if (counter == 4'd0)
                    state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            counter    <= '0;
            last_grant <= 1'b1;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            resp_dz    <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (grant0) begin
                        op_a       <= req0_a;
                        op_b       <= req0_b;
                        op_id      <= 1'b0;
                        last_grant <= 1'b0;
                        counter    <= LOAD;
                    end else if (grant1) begin
                        op_a       <= req1_a;
                        op_b       <= req1_b;
                        op_id      <= 1'b1;
                        last_grant <= 1'b1;
                        counter    <= LOAD;
                    end
                end
                BUSY: begin
                    if (counter == 4'd0) begin
                        resp_data <= div_result;
                        resp_id   <= op_id;
                        resp_dz   <= (op_b[30:0] == 31'd0);
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign div_a      = op_a;
    assign div_b      = op_b;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fpu_div_ctrl.sv
// Bench for fpu_div_ctrl: stub divider, transaction-level model,
// directed scenarios followed by a randomized run.
module tb_fpu_div_ctrl;

    localparam int S = 2;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [31:0] div_a, div_b, div_result;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_id, resp_dz, busy;

    int total = 0;
    int bad   = 0;

    fpu_div_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .div_a(div_a), .div_b(div_b), .div_result(div_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .resp_dz(resp_dz),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared divider: exact quotients for the
    // directed operand pairs, an operand-dependent hash otherwise.
    function automatic logic [31:0] div_model(input logic [31:0] a,
                                              input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;
        if (a == 32'h3F800000 && b == 32'h3FC00000) return 32'h3F2AAAAB;
        if (a == 32'hBFA00000 && b == 32'h3FC00000) return 32'hBF555555;
        if (a == 32'h42FE1000 && b == 32'h41878000) return 32'h40F00000;
        return (a * 32'h9E3779B1) ^ {b[12:0], b[31:13]} ^ 32'h5A5A0F0F;
    endfunction

    always_comb div_result = div_model(div_a, div_b);

    // Transaction model: at most one op outstanding, visible S edges
    // after acceptance and retired by the response handshake.
    bit          m_inflight;
    int          m_wait;
    logic [31:0] m_a, m_b, m_data;
    bit          m_id, m_dz, m_last;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0;
        m_wait     = 0;
        m_a        = '0;
        m_b        = '0;
        m_last     = 1;
    endtask

    task automatic cyc(input bit v0, input logic [31:0] a0,
                       input logic [31:0] b0, input bit v1,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input bit rr);
        bit e0, e1, ev;
        @(negedge clk);
        rst_n      = 1'b1;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        resp_ready = rr;
        #1;
        e0 = 0;
        e1 = 0;
        if (!m_inflight) begin
            if (v0 && v1) begin
                e0 = m_last;
                e1 = !m_last;
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        ev = m_inflight && m_wait == 0;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        chk("busy", {31'd0, busy}, {31'd0, m_inflight});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, ev});
        chk("div_a", div_a, m_a);
        chk("div_b", div_b, m_b);
        if (ev) begin
            chk("resp_data", resp_data, m_data);
            chk("resp_id", {31'd0, resp_id}, {31'd0, m_id});
            chk("resp_dz", {31'd0, resp_dz}, {31'd0, m_dz});
        end
        if (m_inflight) begin
            if (ev && rr) m_inflight = 0;
            else if (m_wait > 0) m_wait--;
        end else if (e0 || e1) begin
            m_a        = e0 ? a0 : a1;
            m_b        = e0 ? b0 : b1;
            m_id       = e1;
            m_last     = e1;
            m_data     = div_model(m_a, m_b);
            m_dz       = (m_b[30:0] == 31'd0);
            m_inflight = 1;
            m_wait     = S;
        end
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n, input bit rr);
        for (int i = 0; i < n; i++)
            cyc(0, 32'd0, 32'd0, 0, 32'd0, 32'd0, rr);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0;
        resp_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_resp_dz", {31'd0, resp_dz}, 32'd0);

        // 1.0 / 1.0 with response taken immediately
        cyc(1, 32'h3F800000, 32'h3F800000, 0, 32'd0, 32'd0, 1);
        idle_cycles(S + 2, 1);

        // simultaneous requests after reset: req0 first, then alternate
        pulse_reset();
        for (int i = 0; i < 4 * (S + 2); i++)
            cyc(1, 32'h3F800000, 32'h3FC00000,
                1, 32'hBFA00000, 32'h3FC00000, 1);
        idle_cycles(S + 2, 1);

        // held response with both requesters pending
        cyc(0, 32'd0, 32'd0, 1, 32'h42FE1000, 32'h41878000, 0);
        for (int i = 0; i < S + 5; i++)
            cyc(1, 32'h11111111, 32'h22222222,
                1, 32'h33333333, 32'h44444444, 0);
        idle_cycles(S + 2, 1);

        // negative-zero divisor
        cyc(1, 32'h40400000, 32'h80000000, 0, 32'd0, 32'd0, 1);
        idle_cycles(S + 2, 1);

        // reset while busy drops the op, then a clean op follows
        cyc(1, 32'h40800000, 32'h40000000, 0, 32'd0, 32'd0, 1);
        pulse_reset();
        idle_cycles(S + 2, 1);
        cyc(0, 32'd0, 32'd0, 1, 32'h3F800000, 32'h3F800000, 1);
        idle_cycles(S + 2, 1);

        // request inputs churn while busy
        cyc(1, 32'h41200000, 32'h40A00000, 0, 32'd0, 32'd0, 1);
        for (int i = 0; i < S + 2; i++)
            cyc(1, $urandom, $urandom, 1, $urandom, $urandom, 1);
        idle_cycles(S + 2, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] b0, b1;
            b0 = ($urandom_range(0, 7) == 0) ? {$urandom_range(0, 1) == 1, 31'd0}
                                             : $urandom;
            b1 = ($urandom_range(0, 7) == 0) ? {$urandom_range(0, 1) == 1, 31'd0}
                                             : $urandom;
            if (i % 97 == 50)
                pulse_reset();
            cyc($urandom_range(0, 1) == 1, $urandom, b0,
                $urandom_range(0, 1) == 1, $urandom, b1,
                $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
